// File: rtl/l1_trig_holdoff_scaler.sv
// rtl/l1_trig_holdoff_scaler.sv - per level/beam trigger edge holdoff with periodic double-banked scalers
// Optional L1_TRIG_OVERFLOW_FLAG_EN adds a sticky saturation flag reported on rd_dat_o[31].
module l1_trig_holdoff_scaler #(
  parameter int NBEAMS       = 48,
  parameter int NLEVELS      = 2,
  parameter int SCAL_BITS    = 16,
  parameter int HOLDOFF_BITS = 4,
  parameter int PERIOD_BITS  = 24
) (
  input  logic                      ifclk,
  input  logic                      ifclk_rstb_i,
  input  logic [NLEVELS*NBEAMS-1:0] trig_i,
  input  logic [NBEAMS-1:0]         beam_mask_i,
  input  logic [HOLDOFF_BITS-1:0]   holdoff_i,
  input  logic [PERIOD_BITS-1:0]    period_i,
  input  logic                      run_i,
  output logic [NBEAMS-1:0]         trig_o,
  output logic                      bank_o,
  output logic                      done_o,
  input  logic                      rd_stb_i,
  input  logic [15:0]               rd_adr_i,
  output logic [31:0]               rd_dat_o,
  output logic                      rd_ack_o
);

  localparam int NTOT = NLEVELS * NBEAMS;
  localparam int AW   = (NTOT > 1) ? $clog2(NTOT) : 1;
  localparam logic [SCAL_BITS-1:0] SMAX = '1;

  logic [1:0]                r_rst_sync;
  logic                      w_rstn;
  logic [NTOT-1:0]           r_trig_prev;
  logic [NTOT-1:0]           w_edge;
  logic [NTOT-1:0]           w_accept;
  logic [HOLDOFF_BITS-1:0]   r_hcnt   [NTOT];
  logic [SCAL_BITS-1:0]      r_live   [NTOT];
  logic [SCAL_BITS-1:0]      r_frozen [NTOT];
  logic [PERIOD_BITS-1:0]    r_timer;
  logic                      w_swap;
  logic [NBEAMS-1:0]         r_trig_o;
  logic                      r_bank;
  logic                      r_done;
  logic                      r_rd_ack;
  logic [31:0]               r_rd_dat;
  logic [31:0]               w_rd_word;
  logic [AW-1:0]             w_rd_idx;

  // Assert immediately, release two ifclk edges later so no flop sees a runt deassertion.
  always_ff @(posedge ifclk or negedge ifclk_rstb_i) begin
    if (!ifclk_rstb_i) r_rst_sync <= 2'b00;
    else               r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rstn = r_rst_sync[1];

  always_comb begin
    w_edge   = trig_i & ~r_trig_prev & ~{NLEVELS{beam_mask_i}};
    w_accept = '0;
    for (int i = 0; i < NTOT; i++) begin
      w_accept[i] = w_edge[i] && (r_hcnt[i] == '0);
    end
  end

  // Compare against the live period value so a shortened period swaps on the next cycle.
  assign w_swap = run_i && (period_i != '0) && (r_timer >= (period_i - PERIOD_BITS'(1)));

  always_ff @(posedge ifclk or negedge w_rstn) begin
    if (!w_rstn) begin
      r_trig_prev <= '0;
      r_timer     <= '0;
      r_trig_o    <= '0;
      r_done      <= 1'b0;
      r_bank      <= 1'b0;
      for (int i = 0; i < NTOT; i++) begin
        r_hcnt[i]   <= '0;
        r_live[i]   <= '0;
        r_frozen[i] <= '0;
      end
    end else begin
      r_trig_prev <= trig_i;
      r_trig_o    <= w_accept[NBEAMS-1:0];
      r_done      <= w_swap;
      if (w_swap) r_bank <= ~r_bank;

      if (!run_i || w_swap)     r_timer <= '0;
      else if (period_i != '0)  r_timer <= r_timer + PERIOD_BITS'(1);

      for (int i = 0; i < NTOT; i++) begin
        if (w_accept[i])          r_hcnt[i] <= holdoff_i;
        else if (r_hcnt[i] != '0) r_hcnt[i] <= r_hcnt[i] - HOLDOFF_BITS'(1);

        if (!run_i) begin
          r_live[i] <= '0;
        end else if (w_swap) begin
          r_frozen[i] <= r_live[i];
          r_live[i]   <= w_accept[i] ? SCAL_BITS'(1) : '0;
        end else if (w_accept[i] && (r_live[i] != SMAX)) begin
          r_live[i] <= r_live[i] + SCAL_BITS'(1);
        end
      end
    end
  end

`ifdef L1_TRIG_OVERFLOW_FLAG_EN
  logic [NTOT-1:0] r_ovf_live;
  logic [NTOT-1:0] r_ovf_frz;

  // Flag marks an acceptance lost to saturation, not merely reaching the maximum.
  always_ff @(posedge ifclk or negedge w_rstn) begin
    if (!w_rstn) begin
      r_ovf_live <= '0;
      r_ovf_frz  <= '0;
    end else if (!run_i) begin
      r_ovf_live <= '0;
    end else if (w_swap) begin
      r_ovf_frz  <= r_ovf_live;
      r_ovf_live <= '0;
    end else begin
      for (int i = 0; i < NTOT; i++) begin
        if (w_accept[i] && (r_live[i] == SMAX)) r_ovf_live[i] <= 1'b1;
      end
    end
  end
`endif

  assign w_rd_idx = rd_adr_i[AW-1:0];

  always_comb begin
    w_rd_word = '0;
    if (rd_adr_i < 16'(NTOT)) begin
      w_rd_word[SCAL_BITS-1:0] = r_frozen[w_rd_idx];
`ifdef L1_TRIG_OVERFLOW_FLAG_EN
      w_rd_word[31] = r_ovf_frz[w_rd_idx];
`endif
    end
  end

  always_ff @(posedge ifclk or negedge w_rstn) begin
    if (!w_rstn) begin
      r_rd_ack <= 1'b0;
      r_rd_dat <= '0;
    end else begin
      r_rd_ack <= rd_stb_i;
      r_rd_dat <= rd_stb_i ? w_rd_word : '0;
    end
  end

  assign trig_o   = r_trig_o;
  assign bank_o   = r_bank;
  assign done_o   = r_done;
  assign rd_ack_o = r_rd_ack;
  assign rd_dat_o = r_rd_dat;

endmodule

// File: tb/tb_l1_trig_holdoff_scaler.sv
// tb/tb_l1_trig_holdoff_scaler.sv - directed bench for l1_trig_holdoff_scaler (48 beams, 2 levels, 4-bit scalers)
module tb_l1_trig_holdoff_scaler;

  localparam int NB = 48;
  localparam int NL = 2;
`ifdef L1_TRIG_OVERFLOW_FLAG_EN
  localparam logic [31:0] SAT_EXP = 32'h8000_000F;
`else
  localparam logic [31:0] SAT_EXP = 32'h0000_000F;
`endif

  logic           clk;
  logic           rstb;
  logic [NL*NB-1:0] trig;
  logic [NB-1:0]  mask;
  logic [3:0]     holdoff;
  logic [23:0]    period;
  logic           run;
  logic [NB-1:0]  trig_o;
  logic           bank;
  logic           done;
  logic           stb;
  logic [15:0]    adr;
  logic [31:0]    dat;
  logic           ack;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int last_done = 0;
  int t2_cnt   = 0;

  l1_trig_holdoff_scaler #(
    .NBEAMS(NB), .NLEVELS(NL), .SCAL_BITS(4), .HOLDOFF_BITS(4), .PERIOD_BITS(24)
  ) dut (
    .ifclk(clk), .ifclk_rstb_i(rstb), .trig_i(trig), .beam_mask_i(mask),
    .holdoff_i(holdoff), .period_i(period), .run_i(run), .trig_o(trig_o),
    .bank_o(bank), .done_o(done), .rd_stb_i(stb), .rd_adr_i(adr),
    .rd_dat_o(dat), .rd_ack_o(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin
      done_cnt++;
      last_done = cyc;
    end
    if (trig_o[2]) t2_cnt++;
  endtask

  task automatic pulse(input int idx);
    trig[idx] = 1'b1;
    tick();
    trig[idx] = 1'b0;
    tick();
  endtask

  task automatic rd(input int a, output logic [31:0] d, output logic k);
    stb = 1'b1;
    adr = 16'(a);
    tick();
    d   = dat;
    k   = ack;
    stb = 1'b0;
  endtask

  task automatic wait_done(input int target, input int lim);
    int n;
    n = 0;
    while (done_cnt < target && n < lim) begin
      tick();
      n++;
    end
    check("wait_done", done_cnt, target);
  endtask

  initial begin
    logic [31:0] d;
    logic        k;
    logic [31:0] pm;
    int          d1;
    int          pc;
    int          snap;

    rstb = 1'b0; trig = '0; mask = '0; holdoff = '0; period = '0;
    run = 1'b0; stb = 1'b0; adr = '0;
    tick(); tick();
    check("rst_trig_o", trig_o, 0);
    check("rst_done", done, 0);
    check("rst_bank", bank, 0);
    check("rst_ack", ack, 0);
    check("rst_dat", dat, 0);
    rstb = 1'b1;
    repeat (4) tick();

    // holdoff 3, beam 5 toggled every 2 cycles: accepts at 0,4,8,12,16
    holdoff = 4'd3;
    pm = '0;
    for (int i = 0; i < 20; i++) begin
      trig[5] = (i % 2 == 0);
      tick();
      pm[i] = trig_o[5];
    end
    trig[5] = 1'b0;
    check("ho3_pattern", pm, 32'h0001_1111);

    holdoff = 4'd0;
    pm = '0;
    for (int i = 0; i < 8; i++) begin
      trig[5] = (i % 2 == 0);
      tick();
      pm[i] = trig_o[5];
    end
    trig[5] = 1'b0;
    check("ho0_pattern", pm, 32'h0000_0055);

    // first period: 7 edges level1 beam0, masked beam 2, 20 edges for saturation
    mask[2] = 1'b1;
    period  = 24'd100;
    run     = 1'b1;
    d1      = cyc;
    t2_cnt  = 0;
    for (int i = 0; i < 7; i++) pulse(NB);
    for (int i = 0; i < 2; i++) pulse(2);
    for (int i = 0; i < 2; i++) pulse(NB + 2);
    for (int i = 0; i < 20; i++) pulse(1);
    check("mask_no_trig_o2", t2_cnt, 0);
    check("done_before_term", done_cnt, 0);
    wait_done(1, 200);
    check("swap1_latency", last_done - d1, 100);
    check("swap1_bank", bank, 1);
    d1 = last_done;

    rd(NB, d, k);      check("rd_l1b0", d, 7); check("rd_l1b0_ack", k, 1);
    rd(1, d, k);       check("rd_sat", d, SAT_EXP);
    rd(2, d, k);       check("rd_mask_l0", d, 0);
    rd(NB + 2, d, k);  check("rd_mask_l1", d, 0);
    rd(200, d, k);     check("rd_oor", d, 0); check("rd_oor_ack", k, 1);

    stb = 1'b1; adr = 16'(NB);
    tick(); check("b2b0_ack", ack, 1); check("b2b0_dat", dat, 7);
    adr = 16'd1;
    tick(); check("b2b1_ack", ack, 1); check("b2b1_dat", dat, SAT_EXP);
    adr = 16'd200;
    tick(); check("b2b2_ack", ack, 1); check("b2b2_dat", dat, 0);
    stb = 1'b0;
    tick(); check("b2b_end_ack", ack, 0);

    // second period: 3 edges, then one more on the swap cycle itself
    for (int i = 0; i < 3; i++) pulse(NB);
    while (cyc < d1 + 99) tick();
    trig[NB] = 1'b1;
    stb = 1'b1; adr = 16'(NB);
    tick();
    check("swap2_done", done, 1);
    check("swap2_rd_pre", dat, 7);
    trig[NB] = 1'b0;
    stb = 1'b0;
    check("swap2_bank", bank, 0);
    rd(NB, d, k); check("rd_excl_swap_edge", d, 3);
    wait_done(3, 200);
    check("swap3_latency", last_done - d1, 200);
    rd(NB, d, k); check("rd_swap_edge_next", d, 1);
    check("swap3_bank", bank, 1);

    // shorten period mid-way: timer already past the new terminal count
    repeat (50) tick();
    period = 24'd10;
    tick();
    check("pchg_done", done, 1);
    check("pchg_cnt", done_cnt, 4);
    pc = last_done;
    wait_done(5, 30);
    check("pchg_next_latency", last_done - pc, 10);
    check("swap5_bank", bank, 1);
    period = 24'd100;

    // reset mid-period with live count 9
    for (int i = 0; i < 9; i++) pulse(0);
    stb = 1'b1; adr = 16'd1;
    tick();
    stb = 1'b0;
    check("pre_rst_ack", ack, 1);
    rstb = 1'b0;
    #1;
    check("rst_async_ack", ack, 0);
    check("rst_async_bank", bank, 0);
    check("rst_async_trig_o", trig_o, 0);
    snap = done_cnt;
    run  = 1'b0;
    repeat (3) tick();
    check("rst_hold_done", done, 0);
    check("rst_no_swap", done_cnt, snap);
    rstb = 1'b1;
    repeat (3) tick();
    rd(0, d, k); check("post_rst_rd0", d, 0); check("post_rst_ack", k, 1);
    rd(NB, d, k); check("post_rst_rd48", d, 0);

    repeat (120) tick();
    check("run0_no_swap", done_cnt, snap);
    check("run0_bank", bank, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_trig_holdoff_scaler.md
L1_TRIG_HOLDOFF_SCALER -- requirements
Module: l1_trig_holdoff_scaler

Interface
REQ-001 SHALL have parameter NBEAMS, default 48, number of beams.
REQ-002 SHALL have parameter NLEVELS, default 2, trigger levels per beam (0 = real, 1..NLEVELS-1 = subthresholds).
REQ-003 SHALL have parameter SCAL_BITS, default 16, scaler width, 1..31.
REQ-004 SHALL have parameter HOLDOFF_BITS, default 4, holdoff counter width.
REQ-005 SHALL have parameter PERIOD_BITS, default 24, period timer width.
REQ-006 SHALL have port: ifclk  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port: ifclk_rstb_i  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port: trig_i  in  NLEVELS*NBEAMS  level-held triggers; index = level*NBEAMS+beam.
REQ-009 SHALL have port: beam_mask_i  in  NBEAMS  1 = beam disabled, all levels.
REQ-010 SHALL have port: holdoff_i  in  HOLDOFF_BITS  dead cycles after an accepted trigger.
REQ-011 SHALL have port: period_i  in  PERIOD_BITS  scaler period in ifclk cycles; 0 = timer stopped.
REQ-012 SHALL have port: run_i  in  1  1 = count; 0 = clear live counters and timer.
REQ-013 SHALL have port: trig_o  out  NBEAMS  one-cycle level-0 accepted pulses.
REQ-014 SHALL have port: bank_o  out  1  toggles at every bank swap.
REQ-015 SHALL have port: done_o  out  1  one-cycle pulse on bank swap.
REQ-016 SHALL have ports: rd_stb_i in 1, rd_adr_i in 16, rd_dat_o out 32, rd_ack_o out 1  scaler readout.

Function
REQ-017 Per level/beam, edge = trig_i bit high and previous-cycle value low and beam not masked.
REQ-018 Per level/beam holdoff counter: edge accepted only when counter==0; on acceptance, counter loads holdoff_i; nonzero counter decrements by 1 per cycle.
REQ-019 holdoff_i=0: every edge accepted; holdoff_i=N: next acceptance possible N+1 cycles later at earliest.
REQ-020 trig_o[b] SHALL be registered: high exactly one cycle, one cycle after the level-0 acceptance cycle.
REQ-021 Live scaler per level/beam increments on acceptance when run_i=1, saturating at 2^SCAL_BITS-1.
REQ-022 Timer counts 0..period_i-1 while run_i=1 and period_i!=0; on terminal count: wraps to 0, all live scalers copy to frozen bank, live scalers clear, done_o pulses, bank_o toggles -- all in the same registered update.
REQ-023 An acceptance on the swap cycle SHALL be counted in the new period (live scaler loads 1), not in the frozen value.
REQ-024 period_i changed mid-period: terminal compare uses the current value; if timer >= new period_i-1, swap occurs next cycle.
REQ-025 run_i=0: timer and live scalers held at 0, no swaps; holdoff, trig_o and frozen bank still operate/retained.
REQ-026 Readout: rd_stb_i sampled at cycle N; rd_ack_o high and rd_dat_o valid at cycle N+1, single cycle; address = level*NBEAMS+beam; rd_dat_o[SCAL_BITS-1:0] = frozen bank value as of cycle N, upper bits 0.
REQ-027 Read coinciding with a swap SHALL return the pre-swap frozen value.
REQ-028 Address >= NLEVELS*NBEAMS SHALL return 0 with ack.
REQ-029 Back-to-back rd_stb_i every cycle SHALL be acked every cycle.

Reset
REQ-030 On ifclk_rstb_i low: trig_o=0, done_o=0, bank_o=0, rd_ack_o=0, rd_dat_o=0, timer, holdoff counters, edge history, live and frozen scalers all 0.
REQ-031 Reset asserted mid-period SHALL take effect immediately without a swap; release synchronised to ifclk internally, first edge evaluated the cycle after release.

Configuration
REQ-032 Macro L1_TRIG_OVERFLOW_FLAG_EN defined: per level/beam sticky flag set when a live scaler saturates, copied and cleared with the swap, reported on rd_dat_o[31].
REQ-033 L1_TRIG_OVERFLOW_FLAG_EN undefined: no flag storage; rd_dat_o[31]=0 always; saturation unchanged.

Verification
REQ-034 holdoff_i=3, beam 5 level 0 toggled high every 2 cycles for 20 cycles -> trig_o[5] pulses every 4 cycles, 5 pulses total.
REQ-035 period_i=100, run_i=1, 7 edges on level 1 beam 0 -> done_o pulse at cycle 100, read address NBEAMS returns 7, bank_o=1.
REQ-036 Edge accepted on swap cycle -> frozen value excludes it; next period read shows 1.
REQ-037 SCAL_BITS=4, 20 edges in one period -> read returns 15; bit 31 = 1 with macro, 0 without.
REQ-038 beam_mask_i[2]=1 with edges on beam 2 all levels -> no trig_o[2], scalers read 0; read address 200 (NBEAMS=48, NLEVELS=2) -> 0 with ack.
REQ-039 Reset pulsed mid-period with live count 9 -> all outputs 0 during reset, no done_o, next read returns 0.
